// File: rtl/led_tick_ctrl.sv
// Purpose: LED shifter control. Debounces four keys, turns presses into run/speed/dir
//          commands and emits a one-cycle tick at the selected rate.
// Latency: steady key edge -> key_evt_o = 2 + DB_CNT + 1 cycles; command visible one cycle later.
// Backpressure: none. tick_o is a free-running strobe and the shifter must accept every one.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   key_n_i    raw board keys, active-low, asynchronous to clk
//   tick_o     one-cycle strobe, one per period while running
//   dir_o      0 = shift left, 1 = shift right
//   run_o      1 = ticking, 0 = paused
//   speed_o    rate select, period = BASE_CNT >> speed
//   key_evt_o  one-cycle pulse per accepted press, bit i = key i
//
// Build option: define AUTO_REVERSE_EN to reverse dir automatically every REV_TICKS ticks.
// Key map: key0 run/pause, key1 faster, key2 slower, key3 reverse.
module led_tick_ctrl #(
    parameter int unsigned BASE_CNT  = 50000000,
    parameter int unsigned DB_CNT    = 1000000,
    parameter int unsigned REV_TICKS = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_n_i,
    output logic       tick_o,
    output logic       dir_o,
    output logic       run_o,
    output logic [1:0] speed_o,
    output logic [3:0] key_evt_o
);

    localparam int unsigned CNT_W = (BASE_CNT > 1) ? $clog2(BASE_CNT) : 1;
    localparam int unsigned DB_W  = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Resets to released (1) so that reset does not
    // look like a press to the debouncer.
    // ------------------------------------------------------------------
    logic [3:0] key_meta_q;
    logic [3:0] key_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= key_n_i;
            key_sync_q <= key_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: the synced level must disagree with the stable level for
    // DB_CNT consecutive cycles before it is accepted. Any agreement in
    // between restarts the count, so short glitches are ignored.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [3:0]      stable_q;
    logic [3:0]      stable_d;
    logic [3:0]      stable_dly_q;
    logic [3:0]      key_evt_q;
    logic [3:0]      key_evt_d;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (key_sync_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = key_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        // Press = stable falling edge; release produces nothing.
        key_evt_d = stable_dly_q & ~stable_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            stable_q     <= '1;
            stable_dly_q <= '1;
            key_evt_q    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            key_evt_q    <= key_evt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command decode from the registered press pulses. key1 and key2 in
    // the same cycle cancel. A press at the saturation limit is a no-op
    // and must not disturb the tick phase.
    // ------------------------------------------------------------------
    logic       run_q;
    logic       run_d;
    logic [1:0] speed_q;
    logic [1:0] speed_d;
    logic       speed_inc;
    logic       speed_dec;
    logic       speed_chg;

    always_comb begin
        speed_inc = key_evt_q[1] & ~key_evt_q[2] & (speed_q != 2'd3);
        speed_dec = key_evt_q[2] & ~key_evt_q[1] & (speed_q != 2'd0);
        speed_chg = speed_inc | speed_dec;
        speed_d   = speed_q;
        if (speed_inc) begin
            speed_d = speed_q + 2'd1;
        end else if (speed_dec) begin
            speed_d = speed_q - 2'd1;
        end
        run_d = run_q ^ key_evt_q[0];
    end

    // ------------------------------------------------------------------
    // Tick counter: counts 0..P-1 with P = BASE_CNT >> speed. It follows
    // the run level from before a key0 edge, so the pause edge still counts
    // and the resume edge does not. A real speed change restarts the period.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic [31:0]      per_m1;
    logic             at_end;

    always_comb begin
        per_m1     = (32'(BASE_CNT) >> speed_q) - 32'd1;
        at_end     = (32'(tick_cnt_q) == per_m1);
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (speed_chg) begin
            tick_cnt_d = '0;
        end else if (run_q) begin
            if (at_end) begin
                tick_d     = 1'b1;
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction.
    // ------------------------------------------------------------------
    logic dir_q;
    logic dir_d;

`ifdef AUTO_REVERSE_EN
    localparam int unsigned REV_W = $clog2(REV_TICKS + 1);
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(REV_TICKS - 1);

    logic [REV_W-1:0] rev_cnt_q;
    logic [REV_W-1:0] rev_cnt_d;

    // A manual reversal restarts the ping-pong count; if it lands on the
    // same tick as an automatic reversal, dir flips only once.
    always_comb begin
        dir_d     = dir_q;
        rev_cnt_d = rev_cnt_q;
        if (key_evt_q[3]) begin
            dir_d     = ~dir_q;
            rev_cnt_d = '0;
        end else if (tick_d) begin
            if (rev_cnt_q == REV_LAST) begin
                dir_d     = ~dir_q;
                rev_cnt_d = '0;
            end else begin
                rev_cnt_d = rev_cnt_q + REV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rev_cnt_q <= '0;
        end else begin
            rev_cnt_q <= rev_cnt_d;
        end
    end
`else
    always_comb begin
        dir_d = dir_q ^ key_evt_q[3];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b1;
            speed_q    <= 2'd0;
            dir_q      <= 1'b0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            run_q      <= run_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign dir_o     = dir_q;
    assign run_o     = run_q;
    assign speed_o   = speed_q;
    assign key_evt_o = key_evt_q;

endmodule
